// File: rtl/module_bram_port_arbiter_pkg.sv
// Shared types for the BRAM port arbiter: FSM state encoding, requester IDs
// and the fixed-priority/urgent-debug winner selection.
package module_bram_port_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [15:0] DBG_REFRESH_DEFAULT  = 16'd50000;
  localparam logic [7:0]  DBG_MAX_WAIT_DEFAULT = 8'd64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REQ_CPU = 2'd0,
    REQ_LDR = 2'd1,
    REQ_DBG = 2'd2
  } req_id_t;

  // An aged debug refresh overrides priority once; otherwise CPU > loader > debug.
  // When nothing requests the result is REQ_DBG, so callers qualify it with "any request".
  function automatic req_id_t pick_winner(
    input logic cpu_req,
    input logic ldr_req,
    input logic dbg_pending,
    input logic dbg_urgent
  );
    if (dbg_pending && dbg_urgent) begin
      return REQ_DBG;
    end else if (cpu_req) begin
      return REQ_CPU;
    end else if (ldr_req) begin
      return REQ_LDR;
    end else begin
      return REQ_DBG;
    end
  endfunction

endpackage

// File: rtl/module_bram_port_arbiter_if.sv
// Requester, debug-viewer and BRAM-side signals of the port arbiter.
// slave = arbiter view, master = environment (requesters + BRAM) view.
interface module_bram_port_arbiter_if;

  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_ack;

  logic       ldr_req;
  logic       ldr_we;
  logic [7:0] ldr_addr;
  logic [7:0] ldr_wdata;
  logic [7:0] ldr_rdata;
  logic       ldr_ack;

  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;

  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic       busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_ack,
    input  dbg_addr,
    output dbg_data,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_ack,
    output dbg_addr,
    input  dbg_data,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/module_bram_port_arbiter_dbg_refresh_tracker.sv
// Decides when the debug viewer byte must be re-read (periodic tick or address change)
// and how long that refresh has been waiting for the port.
module module_dbg_refresh_tracker
  import module_bram_port_arbiter_pkg::*;
#(
  parameter logic [15:0] DBG_REFRESH  = DBG_REFRESH_DEFAULT,
  parameter logic [7:0]  DBG_MAX_WAIT = DBG_MAX_WAIT_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic              i_dbg_grant,
  output logic              o_dbg_pending,
  output logic              o_dbg_urgent
);

  logic [15:0]       r_refresh_cnt;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_pending;
  logic [7:0]        r_age;

  logic w_refresh_hit;
  logic w_addr_changed;

  assign w_refresh_hit  = (r_refresh_cnt == (DBG_REFRESH - 16'd1));
  assign w_addr_changed = (i_dbg_addr != r_last_addr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_refresh_cnt <= '0;
      r_last_addr   <= '0;
      r_pending     <= 1'b1;
      r_age         <= '0;
    end else begin
      r_refresh_cnt <= w_refresh_hit ? 16'd0 : r_refresh_cnt + 16'd1;

      // The grant snapshots the debug address, so a change during the access shows
      // up as a fresh mismatch afterwards and queues another read.
      if (i_dbg_grant) begin
        r_last_addr <= i_dbg_addr;
        r_pending   <= w_refresh_hit;
      end else if (w_refresh_hit || w_addr_changed) begin
        r_pending   <= 1'b1;
      end

      if (i_dbg_grant || !r_pending) begin
        r_age <= '0;
      end else if (r_age < DBG_MAX_WAIT) begin
        r_age <= r_age + 8'd1;
      end
    end
  end

  assign o_dbg_pending = r_pending;
  assign o_dbg_urgent  = r_pending && (r_age >= DBG_MAX_WAIT);

endmodule

// File: rtl/module_bram_port_arbiter.sv
// Single-port 256x8 BRAM arbiter for CPU, program loader and debug viewer;
// each access runs IDLE -> ACCESS -> CAPTURE -> DONE with registered outputs.
module module_bram_port_arbiter
  import module_bram_port_arbiter_pkg::*;
#(
  parameter logic [15:0] DBG_REFRESH  = DBG_REFRESH_DEFAULT,
  parameter logic [7:0]  DBG_MAX_WAIT = DBG_MAX_WAIT_DEFAULT
) (
  input logic                       qzt_clk,
  input logic                       reset_n,
  module_bram_port_arbiter_if.slave bus
);

  state_t            r_state;
  req_id_t           r_winner;
  logic              r_we;
  logic              r_busy;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_ack;
  logic [DATA_W-1:0] r_ldr_rdata;
  logic              r_ldr_ack;
  logic [DATA_W-1:0] r_dbg_data;

  logic              w_dbg_pending;
  logic              w_dbg_urgent;
  logic              w_any_req;
  logic              w_dbg_grant;
  req_id_t           w_winner;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_any_req   = bus.cpu_req | bus.ldr_req | w_dbg_pending;
  assign w_winner    = pick_winner(bus.cpu_req, bus.ldr_req, w_dbg_pending, w_dbg_urgent);
  assign w_dbg_grant = (r_state == ST_IDLE) && w_any_req && (w_winner == REQ_DBG);

  // Debug accesses are always reads of the current debug address.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = bus.dbg_addr;
    w_sel_wdata = '0;
    case (w_winner)
      REQ_CPU: begin
        w_sel_we    = bus.cpu_we;
        w_sel_addr  = bus.cpu_addr;
        w_sel_wdata = bus.cpu_wdata;
      end
      REQ_LDR: begin
        w_sel_we    = bus.ldr_we;
        w_sel_addr  = bus.ldr_addr;
        w_sel_wdata = bus.ldr_wdata;
      end
      default: begin
      end
    endcase
  end

  module_dbg_refresh_tracker #(
    .DBG_REFRESH  (DBG_REFRESH),
    .DBG_MAX_WAIT (DBG_MAX_WAIT)
  ) u_dbg_refresh_tracker (
    .i_clk         (qzt_clk),
    .i_rst_n       (reset_n),
    .i_dbg_addr    (bus.dbg_addr),
    .i_dbg_grant   (w_dbg_grant),
    .o_dbg_pending (w_dbg_pending),
    .o_dbg_urgent  (w_dbg_urgent)
  );

  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_winner    <= REQ_CPU;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_ldr_rdata <= '0;
      r_ldr_ack   <= 1'b0;
      r_dbg_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_winner    <= w_winner;
            r_we        <= w_sel_we;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_busy      <= 1'b1;
            r_state     <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_state  <= ST_CAPTURE;
        end

        // BRAM output is valid now; on writes it carries the old byte and is dropped.
        ST_CAPTURE: begin
          case (r_winner)
            REQ_CPU: begin
              if (!r_we) r_cpu_rdata <= bus.mem_rdata;
              r_cpu_ack <= 1'b1;
            end
            REQ_LDR: begin
              if (!r_we) r_ldr_rdata <= bus.mem_rdata;
              r_ldr_ack <= 1'b1;
            end
            default: begin
              r_dbg_data <= bus.mem_rdata;
            end
          endcase
          r_state <= ST_DONE;
        end

        ST_DONE: begin
          r_cpu_ack <= 1'b0;
          r_ldr_ack <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.ldr_rdata = r_ldr_rdata;
  assign bus.ldr_ack   = r_ldr_ack;
  assign bus.dbg_data  = r_dbg_data;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_module_bram_port_arbiter.sv
// Directed bench for the BRAM port arbiter with a read-first 256x8 BRAM model.
module tb_module_bram_port_arbiter;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_err;

  module_bram_port_arbiter_if bus ();

  module_bram_port_arbiter dut (
    .qzt_clk (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // BRAM model: synchronous, read-first, contents preloaded on the first edge.
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;

  function automatic logic [7:0] init_byte(input int a);
    case (a)
      'h00:    return 8'hA5;
      'h05:    return 8'h55;
      'h06:    return 8'h6E;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic       is_ldr;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  // One transaction on a single port; the request fields are corrupted once the
  // access has been granted, which must not affect the result.
  task automatic run_txn(input int idx, input vec_t v);
    int lat;
    int rd;
    lat = -1;
    @(posedge clk); #1;
    if (v.is_ldr) begin
      bus.ldr_we = v.we; bus.ldr_addr = v.addr; bus.ldr_wdata = v.wdata; bus.ldr_req = 1'b1;
    end else begin
      bus.cpu_we = v.we; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata; bus.cpu_req = 1'b1;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (v.is_ldr) begin
          bus.ldr_we = ~bus.ldr_we; bus.ldr_addr = ~bus.ldr_addr; bus.ldr_wdata = ~bus.ldr_wdata;
        end else begin
          bus.cpu_we = ~bus.cpu_we; bus.cpu_addr = ~bus.cpu_addr; bus.cpu_wdata = ~bus.cpu_wdata;
        end
      end
      if (v.is_ldr ? bus.ldr_ack : bus.cpu_ack) begin
        lat = k;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    rd = v.is_ldr ? int'(bus.ldr_rdata) : int'(bus.cpu_rdata);
    check($sformatf("vec%0d_ack_latency", idx), lat, 3);
    check($sformatf("vec%0d_rdata", idx), rd, int'(v.exp_rdata));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  int t0;
  int first_a;
  int first_b;
  int seen_addr;
  int n_en;

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    bus.dbg_addr = 8'h00;

    //             is_ldr we    addr   wdata  exp_rdata
    vecs[0]  = '{1'b0, 1'b1, 8'h10, 8'h3C, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h3C};
    vecs[2]  = '{1'b1, 1'b1, 8'h20, 8'h5A, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h5A};
    vecs[4]  = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h5A};
    vecs[5]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h3C};
    vecs[6]  = '{1'b0, 1'b1, 8'hFF, 8'h81, 8'h5A};
    vecs[7]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h81};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hA5};
    vecs[9]  = '{1'b1, 1'b1, 8'h00, 8'hC3, 8'h81};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hC3};

    // Reset state, then the automatic debug read of address 0 after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", int'(bus.mem_en), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cpu_ack", int'(bus.cpu_ack), 0);
    check("rst_dbg_data", int'(bus.dbg_data), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("c0_busy", int'(bus.busy), 0);
    @(negedge clk);
    check("c1_mem_en", int'(bus.mem_en), 1);
    check("c1_mem_addr", int'(bus.mem_addr), 'h00);
    check("c1_mem_we", int'(bus.mem_we), 0);
    @(negedge clk);
    check("c2_dbg_data_held", int'(bus.dbg_data), 0);
    @(negedge clk);
    check("c3_dbg_data", int'(bus.dbg_data), 'hA5);
    check("c3_no_acks", int'({bus.cpu_ack, bus.ldr_ack}), 0);
    @(negedge clk);
    check("c4_busy", int'(bus.busy), 0);

    for (int i = 0; i < 11; i++) run_txn(i, vecs[i]);

    // CPU and loader request in the same cycle.
    @(posedge clk); #1;
    bus.cpu_we = 1'b1; bus.cpu_addr = 8'h30; bus.cpu_wdata = 8'h11; bus.cpu_req = 1'b1;
    bus.ldr_we = 1'b0; bus.ldr_addr = 8'h10; bus.ldr_wdata = 8'h00; bus.ldr_req = 1'b1;
    first_a = -1; first_b = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.cpu_ack && first_a < 0) begin first_a = k; bus.cpu_req = 1'b0; end
      if (bus.ldr_ack) begin first_b = k; bus.ldr_req = 1'b0; break; end
    end
    check("simul_cpu_latency", first_a, 3);
    check("simul_ldr_latency", first_b, 7);
    check("simul_ldr_rdata", int'(bus.ldr_rdata), 'h3C);

    // CPU saturates the port; a debug address change must still be served once it has aged.
    @(posedge clk); #1;
    bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10; bus.cpu_req = 1'b1;
    repeat (6) @(posedge clk); #1;
    bus.dbg_addr = 8'h20;
    t0 = cyc;
    first_a = -1; first_b = -1;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        if (bus.mem_addr == 8'h20 && first_a < 0) first_a = cyc - t0;
        else if (bus.mem_addr == 8'h10 && first_a >= 0 && first_b < 0) first_b = cyc - t0;
      end
    end
    check("starve_dbg_access_offset", first_a, 67);
    check("starve_cpu_resume_offset", first_b, 71);
    first_a = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin first_a = 1; bus.cpu_req = 1'b0; break; end
    end
    check("starve_cpu_ack_seen", first_a, 1);
    @(negedge clk);
    check("starve_dbg_data", int'(bus.dbg_data), 'h5A);
    check("starve_cpu_rdata", int'(bus.cpu_rdata), 'h3C);

    // Debug address 05 -> 06 with no other traffic.
    @(posedge clk); #1;
    bus.dbg_addr = 8'h05;
    repeat (8) @(posedge clk); #1;
    check("dbg05_dbg_data", int'(bus.dbg_data), 'h55);
    bus.dbg_addr = 8'h06;
    t0 = cyc;
    first_a = -1; seen_addr = -1; n_en = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        n_en++;
        if (first_a < 0) begin first_a = cyc - t0; seen_addr = int'(bus.mem_addr); end
      end
    end
    check("dbg06_access_offset", first_a, 2);
    check("dbg06_access_addr", seen_addr, 'h06);
    check("dbg06_access_count", n_en, 1);
    check("dbg06_dbg_data", int'(bus.dbg_data), 'h6E);
    n_en = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.mem_en) n_en++;
    end
    check("quiet_no_rereads", n_en, 0);

    // Next periodic refresh lands at a fixed cycle counted from reset release.
    first_a = -1; seen_addr = -1;
    for (int k = 0; k < 60000; k++) begin
      @(negedge clk);
      if (bus.mem_en) begin first_a = cyc; seen_addr = int'(bus.mem_addr); break; end
    end
    check("refresh_cycle", first_a, 50001);
    check("refresh_addr", seen_addr, 'h06);

    // Reset during the ACCESS cycle of a CPU write aborts it.
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    bus.cpu_we = 1'b1; bus.cpu_addr = 8'h40; bus.cpu_wdata = 8'h77; bus.cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_access_mem_en", int'(bus.mem_en), 1);
    check("abort_access_mem_we", int'(bus.mem_we), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_mem_en_drop", int'(bus.mem_en), 0);
    check("abort_mem_we_drop", int'(bus.mem_we), 0);
    bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_release_busy", int'(bus.busy), 0);
    n_en = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.cpu_ack) n_en++;
    end
    check("abort_no_cpu_ack", n_en, 0);
    check("abort_mem40_unwritten", int'(mem[8'h40]), 0);
    check("abort_dbg_reread", int'(bus.dbg_data), 'h6E);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
